multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of memory-wait cycles before a trap; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset: asserted when 0, effective immediately, released synchronously to clk.
REQ-004 SHALL have port opcode, input, 7, instruction[6:0] from the instruction register.
REQ-005 SHALL have port branch_taken, input, 1, the branch condition from the ALU, valid in EXECUTE.
REQ-006 SHALL have port mem_ready, input, 1, memory completion for the current request.
REQ-007 SHALL have port stall, input, 1, which holds the controller in FETCH without requesting.
REQ-008 SHALL have outputs pc_write (1), pc_src (1: 0=pc+4, 1=ALU result), ir_write (1), reg_write (1), mem_req (1) and mem_we (1).
REQ-009 SHALL have outputs state (3), halted (1), trap (1), trap_cause (2: 1=illegal opcode, 2=memory timeout) and retired (32, instruction count).

Function
REQ-010 States and encodings SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5, TRAP=6; the state output SHALL reflect the current state.
REQ-011 All control outputs SHALL be Moore-decoded from state, opcode and branch_taken, and SHALL be 0 unless stated otherwise below.
REQ-012 A memory transfer SHALL complete on any rising edge where mem_req=1 and mem_ready=1; a zero-wait access therefore takes one cycle.
REQ-013 FETCH: with stall=1, mem_req=0 and hold. Otherwise mem_req=1 and mem_we=0; when mem_ready=1, ir_write=1 that cycle, then go to DECODE.
REQ-014 DECODE: single cycle.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Opcode 1110011 SHALL go to HALT.
  - Any other opcode SHALL go to TRAP with trap_cause=1.
  - Legal opcodes SHALL go to EXECUTE.
REQ-015 EXECUTE: single cycle.
  - Load or store SHALL go to MEMORY.
  - Branch (1100011) SHALL assert pc_write=1 with pc_src=branch_taken, then go to FETCH.
  - All other opcodes SHALL go to WRITEBACK.
REQ-016 MEMORY: mem_req=1, with mem_we=1 for a store and 0 for a load. On mem_ready=1: a store SHALL assert pc_write=1 with pc_src=0 and go to FETCH; a load SHALL go to WRITEBACK.
REQ-017 WRITEBACK: reg_write=1 and pc_write=1, with pc_src=1 for JAL/JALR and 0 otherwise, then go to FETCH.
REQ-018 Expected cycle counts with zero-wait memory SHALL be: ALU/LUI/AUIPC/JAL/JALR = 4, load = 5, store = 4, branch = 3.
REQ-019 retired SHALL increment by 1 on every pc_write pulse and SHALL wrap from 0xFFFFFFFF to 0.
REQ-020 The wait counter SHALL clear on entry to FETCH or MEMORY and on each completed transfer, and SHALL increment each cycle mem_req=1 and mem_ready=0.
REQ-021 If TIMEOUT≠0 and the wait counter reaches TIMEOUT, the controller SHALL go to TRAP with trap_cause=2 instead of continuing to wait. If mem_ready=1 arrives on that same edge, the transfer completes and no trap occurs.
REQ-022 Stall cycles SHALL NOT count toward the timeout.
REQ-023 HALT SHALL assert halted=1 and TRAP SHALL assert trap=1; both states SHALL be terminal until reset, with all control outputs 0 and retired frozen.
REQ-024 trap_cause SHALL be 0 outside TRAP and SHALL hold its value while in TRAP.

Reset
REQ-025 When reset=0, the controller SHALL asynchronously enter FETCH and clear retired, the wait counter, trap_cause, halted, trap and all control outputs.
REQ-026 Reset asserted mid-transfer SHALL drop mem_req immediately, and the in-flight access SHALL be abandoned.
REQ-027 After reset release, the first mem_req SHALL appear in the first cycle in which stall=0.

Verification
REQ-028 ADD (0110011) with mem_ready tied to 1 -> states 0,1,2,4; reg_write and pc_write high in cycle 4 with pc_src=0; retired=1.
REQ-029 LW with mem_ready delayed 3 cycles in MEMORY -> 3 wait cycles, then WRITEBACK; total 8 cycles; mem_we=0 throughout.
REQ-030 BEQ with branch_taken=1, then BNE with branch_taken=0 -> pc_write pulses in EXECUTE with pc_src=1 and then pc_src=0; 3 cycles each; reg_write never asserted.
REQ-031 Opcode 0000000 -> trap=1 and trap_cause=1 from the cycle after DECODE; outputs held at 0 for 10 further cycles.
REQ-032 TIMEOUT=4 with mem_ready=0 in FETCH -> TRAP with trap_cause=2 after 4 wait cycles; retired unchanged.
REQ-033 ECALL (1110011) -> halted=1; reset pulsed low during the HALT state -> state=0, halted=0, retired=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Multicycle RV32-style control FSM. Sequences FETCH, DECODE,
//            EXECUTE, MEMORY and WRITEBACK. Traps on illegal opcodes or on
//            memory-wait timeout, halts on ECALL and counts retired
//            instructions.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  input  logic        stall,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] retired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Wait-counter value at which one more unacknowledged cycle means timeout.
  localparam logic [CNT_W-1:0] c_WAIT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  localparam logic [6:0] c_OP_ALU    = 7'b0110011;
  localparam logic [6:0] c_OP_ALUI   = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [1:0]       r_trap_cause;
  logic [31:0]      r_retired;

  logic w_is_load;
  logic w_is_store;
  logic w_is_branch;
  logic w_is_jump;
  logic w_is_ecall;
  logic w_is_legal;
  logic w_xfer_done;
  logic w_wait;
  logic w_timeout;

  assign w_is_load   = (opcode == c_OP_LOAD);
  assign w_is_store  = (opcode == c_OP_STORE);
  assign w_is_branch = (opcode == c_OP_BRANCH);
  assign w_is_jump   = (opcode == c_OP_JAL) || (opcode == c_OP_JALR);
  assign w_is_ecall  = (opcode == c_OP_SYSTEM);
  assign w_is_legal  = (opcode == c_OP_ALU) || (opcode == c_OP_ALUI) || w_is_load ||
                       w_is_store || w_is_branch || w_is_jump ||
                       (opcode == c_OP_LUI) || (opcode == c_OP_AUIPC);

  // A transfer completes on any edge with request and ready both high.
  assign w_xfer_done = mem_req & mem_ready;
  assign w_wait      = mem_req & ~mem_ready;
  // Timeout fires on the edge that would bring the counter to TIMEOUT; a
  // ready on that same edge wins because w_wait is then low.
  assign w_timeout   = (TIMEOUT != 0) && w_wait && (r_wait_cnt == c_WAIT_LAST);

  assign state      = r_state;
  assign halted     = (r_state == S_HALT);
  assign trap       = (r_state == S_TRAP);
  assign trap_cause = r_trap_cause;
  assign retired    = r_retired;

  // Moore control decode; everything is forced low while reset is held so an
  // in-flight request is dropped at once.
  always_comb begin
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    if (reset) begin
      case (r_state)
        S_FETCH: begin
          if (!stall) begin
            mem_req  = 1'b1;
            ir_write = mem_ready;
          end
        end
        S_EXECUTE: begin
          if (w_is_branch) begin
            pc_write = 1'b1;
            pc_src   = branch_taken;
          end
        end
        S_MEMORY: begin
          mem_req  = 1'b1;
          mem_we   = w_is_store;
          pc_write = w_is_store & mem_ready;
        end
        S_WRITEBACK: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          pc_src    = w_is_jump;
        end
        default: ;
      endcase
    end
  end

  // State sequencing, memory-wait counter, trap cause and retired counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_FETCH;
      r_wait_cnt   <= '0;
      r_trap_cause <= 2'd0;
      r_retired    <= 32'd0;
    end else begin
      if (pc_write) r_retired <= r_retired + 32'd1;

      // EXECUTE and WRITEBACK are the only states that enter MEMORY or FETCH
      // without a completed transfer, so clearing there covers every entry.
      if (w_xfer_done || (r_state == S_EXECUTE) || (r_state == S_WRITEBACK)) begin
        r_wait_cnt <= '0;
      end else if (w_wait) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end

      case (r_state)
        S_FETCH: begin
          if (w_xfer_done) begin
            r_state <= S_DECODE;
          end else if (w_timeout) begin
            r_state      <= S_TRAP;
            r_trap_cause <= 2'd2;
          end
        end
        S_DECODE: begin
          if (w_is_legal) begin
            r_state <= S_EXECUTE;
          end else if (w_is_ecall) begin
            r_state <= S_HALT;
          end else begin
            r_state      <= S_TRAP;
            r_trap_cause <= 2'd1;
          end
        end
        S_EXECUTE: begin
          if (w_is_load || w_is_store) r_state <= S_MEMORY;
          else if (w_is_branch)        r_state <= S_FETCH;
          else                         r_state <= S_WRITEBACK;
        end
        S_MEMORY: begin
          if (w_xfer_done) begin
            r_state <= w_is_store ? S_FETCH : S_WRITEBACK;
          end else if (w_timeout) begin
            r_state      <= S_TRAP;
            r_trap_cause <= 2'd2;
          end
        end
        S_WRITEBACK: r_state <= S_FETCH;
        S_HALT:      r_state <= S_HALT;
        S_TRAP:      r_state <= S_TRAP;
        default:     r_state <= S_FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire
